// File: rtl/lsu_arbiter.sv
// Shares the single-port load/store unit between the MEM stage (port 0) and a debug/DMA master (port 1).
// One transaction at a time: round-robin grant, registered write-ack wait with timeout, one-cycle response.
module lsu_arbiter #(
  parameter int DEPTH   = 512,
  parameter int IN_LO   = 320,
  parameter int IN_HI   = 383,
  parameter int TIMEOUT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req0_we_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  output logic        req0_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_rdata_o,
  output logic        rsp0_err_o,
  input  logic        req1_valid_i,
  input  logic        req1_we_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        req1_ready_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_rdata_o,
  output logic        rsp1_err_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_dataW_o,
  output logic        lsu_MemRW_o,
  input  logic [31:0] lsu_dataR_i,
  input  logic        lsu_mem_ready_i,
  output logic        busy_o,
  output logic        grant_o,
  output logic [7:0]  err_cnt_o
);

  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_e;

  state_e            state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   waitCnt_q, waitCnt_d;
  logic [7:0]        errCnt_q, errCnt_d;

  logic              sel;
  logic              accept;
  logic              selWe;
  logic [31:0]       selAddr;
  logic [31:0]       selWdata;
  logic              inInputRegion;
  logic              errInc;

  // Round-robin pick; ready is withheld during reset so no request is silently dropped.
  always_comb begin
    if (req0_valid_i && req1_valid_i) sel = ~lastGrant_q;
    else                              sel = req1_valid_i;
    accept   = (state_q == IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
    selWe    = sel ? req1_we_i    : req0_we_i;
    selAddr  = sel ? req1_addr_i  : req0_addr_i;
    selWdata = sel ? req1_wdata_i : req0_wdata_i;
  end

  assign req0_ready_o  = accept && !sel;
  assign req1_ready_o  = accept && sel;
  assign inInputRegion = (addr_q >= 32'(IN_LO)) && (addr_q <= 32'(IN_HI));

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    waitCnt_d   = waitCnt_q;
    errInc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d     = sel;
          lastGrant_d = sel;
          we_d        = selWe;
          addr_d      = selAddr;
          wdata_d     = selWdata;
          rdata_d     = '0;
          waitCnt_d   = '0;
          if (selAddr >= 32'(DEPTH)) begin
            err_d   = 1'b1;
            errInc  = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          waitCnt_d = '0;
          state_d   = WAIT_ACK;
        end else begin
          rdata_d = lsu_dataR_i;
          state_d = RESP;
        end
      end
      WAIT_ACK: begin
        // The input-peripheral region never acknowledges, so any stray ready there is not trusted.
        if (lsu_mem_ready_i && !inInputRegion) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (waitCnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          errInc  = 1'b1;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q + CntW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    errCnt_d = (errInc && errCnt_q != 8'hFF) ? errCnt_q + 8'd1 : errCnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      waitCnt_q   <= '0;
      errCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      waitCnt_q   <= waitCnt_d;
      errCnt_q    <= errCnt_d;
    end
  end

  assign lsu_addr_o   = (state_q == ISSUE || state_q == WAIT_ACK) ? addr_q  : '0;
  assign lsu_dataW_o  = (state_q == ISSUE || state_q == WAIT_ACK) ? wdata_q : '0;
  assign lsu_MemRW_o  = (state_q == ISSUE) && we_q;

  assign rsp0_valid_o = (state_q == RESP) && !owner_q;
  assign rsp1_valid_o = (state_q == RESP) && owner_q;
  assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;
  assign rsp0_err_o   = rsp0_valid_o && err_q;
  assign rsp1_err_o   = rsp1_valid_o && err_q;

  assign busy_o    = (state_q != IDLE);
  assign grant_o   = owner_q;
  assign err_cnt_o = errCnt_q;

endmodule
